branch_resolve_unit: RTL and testbench

// - Parametrised successor to the ID-stage branch comparator: registered branch resolution plus
//   a 2-bit-counter branch history table (BHT) for fetch-time prediction.
// - Request accepted from ID; result, taken flag and mispredict flag presented one cycle later.
// - Fetch reads the prediction for its PC through a combinational lookup port.
// - Resolve results train the BHT.

---
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution with a 2-bit-counter branch history table.
// Optional statistics counters: define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             req_valid,
  input  logic [2:0]       req_cond,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [31:0]      req_pc,
  input  logic             req_pred,
  input  logic [31:0]      lk_pc,
  output logic             lk_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [31:0]      res_pc,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_BEQ  = 3'd1;
  localparam logic [2:0] C_BNE  = 3'd2;
  localparam logic [2:0] C_BLEZ = 3'd3;
  localparam logic [2:0] C_BGTZ = 3'd4;
  localparam logic [2:0] C_BLTZ = 3'd5;
  localparam logic [2:0] C_BGEZ = 3'd6;
  localparam logic [2:0] C_ALW  = 3'd7;

  logic [1:0]       bht [BHT_DEPTH];
  logic             req_taken;
  logic             res_pred;
  logic [2:0]       res_cond;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] tr_idx;
  logic             train;
  logic             a_zero;
  logic             a_neg;
  logic             unused_pc_bits;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign tr_idx = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0],
                            res_pc[31:IDX_W+2], res_pc[1:0]};

  assign a_zero = (req_a == '0);
  assign a_neg  = req_a[WIDTH-1];

  // Branch direction from the condition code and operands
  always_comb begin
    req_taken = 1'b0;
    unique case (req_cond)
      C_NONE: req_taken = 1'b0;
      C_BEQ:  req_taken = (req_a == req_b);
      C_BNE:  req_taken = (req_a != req_b);
      C_BLEZ: req_taken = a_neg | a_zero;
      C_BGTZ: req_taken = !a_neg && !a_zero;
      C_BLTZ: req_taken = a_neg;
      C_BGEZ: req_taken = !a_neg;
      C_ALW:  req_taken = 1'b1;
      default: req_taken = 1'b0;
    endcase
  end

  assign res_mispredict = res_valid & (res_taken != res_pred);

  // A live conditional result commits to the BHT on its first free edge
  assign train = res_valid && !stall && !flush &&
                 (res_cond != C_NONE) && (res_cond != C_ALW);

  assign lk_taken = bht[lk_idx][1];

  // Result stage: flush kills, stall holds, otherwise capture or bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_pred  <= 1'b0;
      res_pc    <= '0;
      res_cond  <= C_NONE;
    end else if (flush) begin
      res_valid <= 1'b0;
      res_taken <= 1'b0;
    end else if (!stall) begin
      if (req_valid) begin
        res_valid <= 1'b1;
        res_taken <= req_taken;
        res_pred  <= req_pred;
        res_pc    <= req_pc;
        res_cond  <= req_cond;
      end else begin
        res_valid <= 1'b0;
        res_taken <= 1'b0;
      end
    end
  end

  // Saturating 2-bit counter training
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (train) begin
      if (res_taken) begin
        if (bht[tr_idx] != 2'b11)
          bht[tr_idx] <= bht[tr_idx] + 2'b01;
      end else begin
        if (bht[tr_idx] != 2'b00)
          bht[tr_idx] <= bht[tr_idx] - 2'b01;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Saturating counts of trained branches and their mispredicts
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (train) begin
      if (stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (res_mispredict && stat_mispred != 32'hFFFF_FFFF)
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (4-entry BHT).
// Vector table, corner sequences, and randomized model comparison.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, flush, req_valid, req_pred;
  logic [2:0]  req_cond;
  logic [31:0] req_a, req_b, req_pc, lk_pc;
  logic        lk_taken, res_valid, res_taken, res_mispredict;
  logic [31:0] res_pc, stat_branches, stat_mispred;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_valid, m_taken, m_pred;
  logic [31:0] m_pc;
  int          m_cond;
  int          m_bht [DEPTH];
  longint      n_br, n_mis;

  branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_cond(req_cond),
    .req_a(req_a), .req_b(req_b), .req_pc(req_pc),
    .req_pred(req_pred), .lk_pc(lk_pc), .lk_taken(lk_taken),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_pc(res_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(int c, logic [31:0] a, logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (c)
      1: return a == b;
      2: return a != b;
      3: return sa <= 0;
      4: return sa > 0;
      5: return sa < 0;
      6: return sa >= 0;
      7: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int ix(logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_step();
    int i;
    if (reset) begin
      m_valid = 0; m_taken = 0; m_pred = 0; m_pc = 0; m_cond = 0;
      for (int k = 0; k < DEPTH; k++) m_bht[k] = 1;
      n_br = 0; n_mis = 0;
    end else begin
      if (m_valid && !stall && !flush && m_cond >= 1 && m_cond <= 6) begin
        i = ix(m_pc);
        if (m_taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
        else         m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
        n_br++;
        if (m_taken != m_pred) n_mis++;
      end
      if (flush) begin
        m_valid = 0; m_taken = 0;
      end else if (!stall) begin
        if (req_valid) begin
          m_valid = 1;
          m_taken = ref_taken(int'(req_cond), req_a, req_b);
          m_pred  = req_pred;
          m_pc    = req_pc;
          m_cond  = int'(req_cond);
        end else begin
          m_valid = 0; m_taken = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_taken", 32'(res_taken), 32'(m_taken));
    chk("res_mispredict", 32'(res_mispredict),
        32'(m_valid && (m_taken != m_pred)));
    if (m_valid) chk("res_pc", res_pc, m_pc);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_branches", stat_branches, 32'(n_br));
    chk("stat_mispred", stat_mispred, 32'(n_mis));
`else
    chk("stat_branches", stat_branches, 32'(n_br * 0));
    chk("stat_mispred", stat_mispred, 32'(n_mis * 0));
`endif
  endtask

  // one clock: lookup check, model update, post-edge output check
  task automatic tick();
    #1;
    chk("lk_taken", 32'(lk_taken), 32'(m_bht[ix(lk_pc)] >= 2));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic req(input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] pc,
                     input logic p);
    stall = 0; flush = 0; reset = 0;
    req_valid = 1; req_cond = c; req_a = a; req_b = b;
    req_pc = pc; req_pred = p;
    tick();
  endtask

  task automatic idle();
    stall = 0; flush = 0; reset = 0; req_valid = 0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; flush = 0; req_valid = 0;
    tick();
    reset = 0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] t [6];
    t[0] = 32'd0; t[1] = 32'd1; t[2] = 32'hFFFF_FFFF;
    t[3] = 32'd5; t[4] = 32'h8000_0000; t[5] = 32'h7FFF_FFFF;
    return t[$urandom_range(0, 5)];
  endfunction

  typedef struct {
    logic [2:0]  cond;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    bit          exp_taken;
    bit          exp_mis;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{3'd1, 32'd5,          32'd5, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3'd2, 32'd5,          32'd5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'd5, 32'h8000_0000,  32'd0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'd4, 32'd0,          32'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'd3, 32'd0,          32'd0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{3'd6, 32'hFFFF_FFFF,  32'd0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{3'd0, 32'd0,          32'd0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{3'd7, 32'd0,          32'd0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{3'd2, 32'd1,          32'd2, 1'b1, 1'b1, 1'b0};

    reset = 1; stall = 0; flush = 0; req_valid = 0; req_pred = 0;
    req_cond = 0; req_a = 0; req_b = 0; req_pc = 0; lk_pc = 32'h3000;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    check_outputs();
    chk("reset_res_pc", res_pc, 32'h0);
    chk("reset_lk", 32'(lk_taken), 32'h0);
    reset = 0;

    // first branch: entry 0 goes 01 -> 10
    req(3'd1, 32'd5, 32'd5, 32'h3000, 1'b0);
    chk("beq_taken", 32'(res_taken), 32'h1);
    chk("beq_mis", 32'(res_mispredict), 32'h1);
    idle();
    chk("beq_trained_lk", 32'(lk_taken), 32'h1);

    // vector table
    for (int i = 0; i < 9; i++) begin
      req(vecs[i].cond, vecs[i].a, vecs[i].b, 32'h3000 + 32'(i * 4),
          vecs[i].pred);
      chk($sformatf("vec%0d_taken", i), 32'(res_taken),
          32'(vecs[i].exp_taken));
      chk($sformatf("vec%0d_mis", i), 32'(res_mispredict),
          32'(vecs[i].exp_mis));
    end
    idle();

    // saturation on entry 1
    do_reset();
    lk_pc = 32'h3004;
    repeat (4) req(3'd1, 32'd7, 32'd7, 32'h3004, 1'b0);
    idle();
    chk("sat_hi_lk", 32'(lk_taken), 32'h1);
    repeat (4) req(3'd2, 32'd7, 32'd7, 32'h3004, 1'b1);
    idle();
    chk("sat_lo_lk", 32'(lk_taken), 32'h0);
    req(3'd1, 32'd7, 32'd7, 32'h3004, 1'b0);
    idle();
    chk("sat_lo_plus1_lk", 32'(lk_taken), 32'h0);
    req(3'd1, 32'd7, 32'd7, 32'h3004, 1'b0);
    idle();
    chk("sat_lo_plus2_lk", 32'(lk_taken), 32'h1);

    // stall holds, single update on release
    do_reset();
    lk_pc = 32'h3008;
    req(3'd1, 32'd3, 32'd3, 32'h3008, 1'b0);
    for (int k = 0; k < 3; k++) begin
      stall = 1; req_valid = 1; req_cond = 3'd7; req_pc = 32'h3FF0;
      tick();
      chk("stall_valid", 32'(res_valid), 32'h1);
      chk("stall_pc", res_pc, 32'h3008);
    end
    idle();
    chk("stall_release_lk", 32'(lk_taken), 32'h1);
    idle();

    // flush with stall: no update
    lk_pc = 32'h300C;
    req(3'd1, 32'd3, 32'd3, 32'h300C, 1'b0);
    stall = 1; flush = 1; req_valid = 1;
    tick();
    chk("flush_stall_valid", 32'(res_valid), 32'h0);
    idle();
    chk("flush_no_train_lk", 32'(lk_taken), 32'h0);

    // cond 0/7 never train; aliasing of 0x3000 and 0x3010
    lk_pc = 32'h3010;
    req(3'd7, 32'd0, 32'd0, 32'h3000, 1'b0);
    req(3'd7, 32'd0, 32'd0, 32'h3000, 1'b0);
    req(3'd0, 32'd0, 32'd0, 32'h3000, 1'b0);
    idle();
    chk("cond07_lk", 32'(lk_taken), 32'h0);
    req(3'd1, 32'd1, 32'd1, 32'h3000, 1'b1);
    idle();
    chk("alias_lk", 32'(lk_taken), 32'h1);

    // reset mid-operation
    req(3'd1, 32'd1, 32'd1, 32'h3010, 1'b1);
    reset = 1; req_valid = 1;
    tick();
    chk("midreset_valid", 32'(res_valid), 32'h0);
    chk("midreset_lk", 32'(lk_taken), 32'h0);
    reset = 0;

    // statistics
    do_reset();
    req(3'd1, 32'd5, 32'd5, 32'h3000, 1'b1);
    req(3'd2, 32'd5, 32'd5, 32'h3004, 1'b0);
    req(3'd3, 32'd1, 32'd0, 32'h3008, 1'b1);
    req(3'd7, 32'd0, 32'd0, 32'h300C, 1'b0);
    idle();
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_br_const", stat_branches, 32'd3);
    chk("stat_mis_const", stat_mispred, 32'd1);
`else
    chk("stat_br_const", stat_branches, 32'd0);
    chk("stat_mis_const", stat_mispred, 32'd0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 99) < 2);
      flush     = ($urandom_range(0, 99) < 8);
      stall     = ($urandom_range(0, 99) < 20);
      req_valid = ($urandom_range(0, 99) < 75);
      req_cond  = 3'($urandom_range(0, 7));
      req_a     = pick();
      req_b     = pick();
      req_pc    = 32'h3000 + 32'($urandom_range(0, 7) * 4);
      req_pred  = 1'($urandom_range(0, 1));
      lk_pc     = 32'h3000 + 32'($urandom_range(0, 7) * 4);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
